// File: rtl/inst_fetch_buffer_if.sv
// Fetch-buffer bus bundle: control, instruction-memory request/response and
// pipeline-facing instruction handshake.
interface inst_fetch_buffer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] end_pc;
    logic              flush;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_resp_valid;
    logic [7:0]        imem_resp_data;
    logic [7:0]        inst;
    logic              inst_valid;
    logic              inst_ready;
    logic              busy;

    modport slave (
        input  start, start_pc, end_pc, flush, imem_req_ready,
               imem_resp_valid, imem_resp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst, inst_valid, busy
    );

    modport master (
        output start, start_pc, end_pc, flush, imem_req_ready,
               imem_resp_valid, imem_resp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst, inst_valid, busy
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// In-order instruction fetch from start_pc..end_pc into a credit-protected
// FIFO feeding the pipeline; flush drops queued and in-flight instructions.
module inst_fetch_buffer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 8,
    parameter int MAX_OUT = 2
) (
    input logic             clk,
    input logic             rst,
    inst_fetch_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, last;
    logic [CW-1:0]     outstanding, drop_cnt, count;
    logic [PW-1:0]     wptr, rptr;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        hold;
    logic              req_valid, accept, push, pop;

    assign req_valid = (state == RUN) && !bus.flush && (drop_cnt == '0)
                     && (outstanding < CW'(MAX_OUT))
                     && (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH));
    assign accept    = req_valid && bus.imem_req_ready;
    assign push      = bus.imem_resp_valid && (drop_cnt == '0) && !bus.flush;
    assign pop       = (count != '0) && bus.inst_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.inst           = (count != '0) ? mem[rptr] : hold;
    assign bus.busy           = (state != IDLE) || (outstanding != '0) || (count != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (accept && pc == last) state_nxt = STOP;
            STOP:    if (outstanding == '0 && count == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            last        <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            hold        <= '0;
        end else begin
            state <= state_nxt;
            hold  <= bus.inst;
            if (state == IDLE && bus.start && !bus.flush) begin
                pc   <= bus.start_pc;
                last <= bus.end_pc;
            end else if (accept) begin
                pc <= pc + 1'b1;
            end
            case ({accept, bus.imem_resp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            // Issue is blocked while drops are pending, so everything in flight
            // is already stale: outstanding alone is the exact drop count.
            if (bus.flush)
                drop_cnt <= outstanding - CW'(bus.imem_resp_valid);
            else if (bus.imem_resp_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - 1'b1;
            if (bus.flush) begin
                count <= '0;
                wptr  <= '0;
                rptr  <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.imem_resp_data;
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized and directed bench for inst_fetch_buffer against a queue-based
// model of fetch sessions, in-flight requests and the instruction FIFO.
module tb_inst_fetch_buffer;
    localparam int DEPTH = 4, ADDR_W = 8, MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_buffer_if #(.ADDR_W(ADDR_W)) bus();
    inst_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {logic [7:0] data; int due; bit drop;} fl_t;

    fl_t        infl[$];
    logic [7:0] fifo[$];
    logic [7:0] acc_log[$], pop_log[$];
    logic [7:0] last_inst, m_pc;
    bit         in_sess;
    int         remaining, cyc;
    int         pass_cnt, total_cnt;
    int         lat_min = 1, lat_max = 1, resp_pct = 100;

    function automatic logic [7:0] data_of(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        infl.delete(); fifo.delete();
        in_sess = 0; m_pc = 8'h00; remaining = 0; last_inst = 8'h00;
    endtask

    // One clock: drive memory response, compare, advance model, move to next negedge.
    task automatic step();
        bit         fire, drop_pend, exp_rv, acc, pop, end_sess;
        logic [7:0] exp_inst, d;
        fl_t        f;
        fire = infl.size() > 0 && infl[0].due <= cyc && ($urandom_range(99) < resp_pct);
        bus.imem_resp_valid = fire;
        bus.imem_resp_data  = fire ? infl[0].data : 8'($urandom);
        #1;
        drop_pend = 0;
        foreach (infl[i]) if (infl[i].drop) drop_pend = 1;
        exp_rv = in_sess && remaining > 0 && !bus.flush && !drop_pend
              && infl.size() < MAX_OUT && infl.size() + fifo.size() < DEPTH;
        exp_inst = fifo.size() != 0 ? fifo[0] : last_inst;
        chk("req_valid", bus.imem_req_valid, exp_rv);
        chk("req_addr", bus.imem_req_addr, m_pc);
        chk("inst_valid", bus.inst_valid, fifo.size() != 0);
        chk("inst", bus.inst, exp_inst);
        chk("busy", bus.busy, in_sess || infl.size() != 0 || fifo.size() != 0);

        acc       = exp_rv && bus.imem_req_ready;
        pop       = fifo.size() != 0 && bus.inst_ready;
        last_inst = exp_inst;
        end_sess  = in_sess && remaining == 0 && infl.size() == 0 && fifo.size() == 0;
        if (pop) pop_log.push_back(fifo.pop_front());
        if (fire) begin
            f = infl.pop_front();
            if (!f.drop && !bus.flush) begin
                fifo.push_back(f.data);
                if (fifo.size() > DEPTH) begin
                    total_cnt++;
                    $display("FAIL fifo_overflow: size %0d exceeds %0d (cycle %0d)", fifo.size(), DEPTH, cyc);
                end
            end
        end
        if (acc) begin
            infl.push_back('{data_of(m_pc), cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
            acc_log.push_back(m_pc);
            m_pc++;
            remaining--;
        end
        if (bus.flush) begin
            fifo.delete();
            foreach (infl[i]) infl[i].drop = 1;
            in_sess = 0;
        end else if (end_sess) begin
            in_sess = 0;
        end else if (!in_sess && bus.start) begin
            in_sess   = 1;
            m_pc      = bus.start_pc;
            d         = bus.end_pc - bus.start_pc;
            remaining = int'(d) + 1;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_start(input logic [7:0] s, input logic [7:0] e);
        bus.start = 1'b1; bus.start_pc = s; bus.end_pc = e;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] e1[4];
        logic [7:0] e3[4];
        pass_cnt = 0; total_cnt = 0; cyc = 0;
        model_reset();
        bus.start = 0; bus.start_pc = 0; bus.end_pc = 0; bus.flush = 0;
        bus.imem_req_ready = 1; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
        bus.inst_ready = 1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_req_addr", bus.imem_req_addr, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk); rst = 1'b0;

        // Plain run 0x10..0x13
        e1 = '{8'h4A, 8'h4B, 8'h48, 8'h49};
        acc_log.delete(); pop_log.delete();
        do_start(8'h10, 8'h13);
        run(12);
        chk("t1_nacc", acc_log.size(), 4);
        chk("t1_npop", pop_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_log.size()) chk("t1_addr", acc_log[i], 8'h10 + i);
            if (i < pop_log.size()) chk("t1_inst", pop_log[i], e1[i]);
        end
        chk("t1_busy", bus.busy, 0);

        // Credit limit with a stalled consumer
        acc_log.delete(); pop_log.delete();
        bus.inst_ready = 0;
        do_start(8'h00, 8'h09);
        run(15);
        chk("t2_credit_acc", acc_log.size(), 4);
        chk("t2_req_off", bus.imem_req_valid, 0);
        bus.inst_ready = 1;
        run(30);
        chk("t2_npop", pop_log.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < pop_log.size()) chk("t2_inst", pop_log[i], data_of(8'(i)));

        // Address wrap
        e3 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        acc_log.delete();
        do_start(8'hFE, 8'h01);
        run(12);
        chk("t3_nacc", acc_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < acc_log.size()) chk("t3_addr", acc_log[i], e3[i]);
        chk("t3_busy", bus.busy, 0);

        // Flush with requests in flight, then restart at 0x40
        lat_min = 3; lat_max = 3;
        bus.inst_ready = 0;
        do_start(8'h20, 8'h2F);
        for (int k = 0; k < 30 && !(infl.size() == 2 && fifo.size() >= 1); k++) step();
        chk("t4_setup", (infl.size() == 2 && fifo.size() >= 1), 1);
        chk("t4_valid_pre", bus.inst_valid, 1);
        bus.flush = 1;
        step();
        bus.flush = 0;
        chk("t4_valid_post", bus.inst_valid, 0);
        pop_log.delete();
        bus.inst_ready = 1;
        do_start(8'h40, 8'h41);
        run(20);
        chk("t4_npop", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            chk("t4_inst0", pop_log[0], 8'h1A);
            chk("t4_inst1", pop_log[1], 8'h1B);
        end

        // Randomized traffic
        lat_min = 1; lat_max = 3; resp_pct = 70;
        for (int k = 0; k < 1500; k++) begin
            bus.imem_req_ready = ($urandom_range(99) < 70);
            bus.inst_ready     = ($urandom_range(99) < 60);
            bus.flush          = ($urandom_range(99) < 2);
            bus.start          = ($urandom_range(99) < 20);
            bus.start_pc       = 8'($urandom);
            bus.end_pc         = bus.start_pc + 8'($urandom_range(12));
            step();
        end
        bus.flush = 0; bus.start = 0;

        // Asynchronous reset mid-run
        lat_min = 1; lat_max = 1; resp_pct = 100;
        bus.imem_req_ready = 1; bus.inst_ready = 0;
        do_start(8'h80, 8'h8F);
        run(3);
        #2 rst = 1'b1;
        #1;
        chk("t6_req_valid", bus.imem_req_valid, 0);
        chk("t6_inst_valid", bus.inst_valid, 0);
        chk("t6_busy", bus.busy, 0);
        model_reset();
        bus.imem_resp_valid = 0;
        @(negedge clk); rst = 1'b0;
        bus.inst_ready = 1;
        run(5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
